// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and default widths used by the data-memory arbiter.
package rv_pipe_pkg;

    localparam int unsigned DefAddrW       = 32;
    localparam int unsigned DefDataW       = 32;
    localparam int unsigned DefStarveLimit = 4;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        RESUME
    } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter: counts refused debug cycles up to LIMIT and flags when LIMIT is reached.
module starve_counter
    import rv_pipe_pkg::*;
#(
    parameter int unsigned LIMIT = DefStarveLimit
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int unsigned      CntW     = $clog2(LIMIT + 1);
    localparam logic [CntW-1:0]  LimitVal = CntW'(LIMIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LimitVal)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LimitVal);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and a debug/loader requester,
// with starvation-bounded debug grants and a halt mode that hands memory to debug every cycle.
module dmem_arbiter
    import rv_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefAddrW,
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              halt_req,
    output logic              halted,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q, state_d;
    logic              at_limit;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (!dbg_valid || dbg_ready),
        .inc      (dbg_valid && !dbg_ready),
        .at_limit (at_limit)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (halt_req) state_d = HALT;
            HALT:    if (!halt_req) state_d = RESUME;
            RESUME:  state_d = halt_req ? HALT : RUN;
            default: state_d = RUN;
        endcase
    end

    // RESUME arbitrates exactly like RUN; only HALT gives debug unconditional ownership.
    always_comb begin
        dbg_ready  = dbg_valid && ((state_q == HALT) || !core_req || at_limit);
        core_stall = (state_q == HALT) || (core_req && dbg_ready);
        if (dbg_ready) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else begin
            mem_we    = core_req && core_we && !core_stall;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dbg_rvalid_q <= dbg_ready;
            if (dbg_ready) begin
                dbg_rdata_q <= dbg_we ? '0 : mem_rdata;
            end
        end
    end

    assign core_rdata = mem_rdata;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a
// behavioural model of grant priority, starvation bound, halt ownership and memory contents.
module tb_dmem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, dbg_valid, dbg_we, halt_req;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        core_stall, dbg_ready, dbg_rvalid, halted, mem_we;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .halt_req   (halt_req),
        .halted     (halted),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Environment memory: synchronous write, asynchronous read, 64 words.
    logic [31:0] mem [64];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[7:2]];

    // Reference model state.
    logic [31:0] ref_mem [64];
    int          m_wait;
    logic        m_halted;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // One arbitrated cycle: drive at negedge, check, then advance the model past the next edge.
    task automatic step(input logic creq, input logic cwe, input logic [31:0] caddr,
                        input logic [31:0] cwdata, input logic dv, input logic dwe,
                        input logic [31:0] daddr, input logic [31:0] dwdata, input logic hreq);
        logic e_ready, e_stall, e_we;
        logic [31:0] e_addr, e_wdata;
        @(negedge clk);
        core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwdata;
        dbg_valid = dv; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwdata; halt_req = hreq;
        #1;
        e_ready = dv && (m_halted || !creq || m_wait >= int'(LIMIT));
        e_stall = m_halted || (creq && e_ready);
        e_we    = e_ready ? dwe : (creq && cwe && !e_stall);
        e_addr  = e_ready ? daddr : caddr;
        e_wdata = e_ready ? dwdata : cwdata;
        check("dbg_ready", {31'd0, dbg_ready}, {31'd0, e_ready});
        check("core_stall", {31'd0, core_stall}, {31'd0, e_stall});
        check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, e_wdata);
        if (creq && !cwe && !e_stall) check("core_rdata", core_rdata, ref_mem[caddr[7:2]]);
        check("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, m_rvalid});
        check("dbg_rdata", dbg_rdata, m_rdata);
        check("halted", {31'd0, halted}, {31'd0, m_halted});
        // Advance the model to the state after the coming rising edge.
        m_rvalid = e_ready;
        if (e_ready) m_rdata = dwe ? 32'd0 : ref_mem[daddr[7:2]];
        if (e_we) ref_mem[e_addr[7:2]] = e_wdata;
        m_wait   = (dv && !e_ready) ? ((m_wait < int'(LIMIT)) ? m_wait + 1 : m_wait) : 0;
        m_halted = hreq;  // every state goes to HALT on halt_req and leaves it otherwise
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic model_reset();
        m_wait = 0; m_halted = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0;
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hA500_0000 + 32'(i);
            ref_mem[i] = 32'hA500_0000 + 32'(i);
        end
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; halt_req = 0;
        model_reset();
        rst = 1'b0;
        #1;
        check("reset_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        check("reset_rdata", dbg_rdata, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle();

        // Idle core: debug write then read back.
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        check("dw_ready", {31'd0, dbg_ready}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
        check("dw_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("dw_rdata0", dbg_rdata, 32'd0);
        idle();
        check("dr_rdata", dbg_rdata, 32'hDEADBEEF);

        // Starvation: continuous core loads against a debug read of 0x20.
        for (int c = 1; c <= int'(LIMIT) + 1; c++) begin
            step(1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
            check("starve_ready", {31'd0, dbg_ready}, (c == int'(LIMIT) + 1) ? 32'd1 : 32'd0);
        end
        step(1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("starve_rdata", dbg_rdata, 32'hA500_0008);
        check("starve_nostall", {31'd0, core_stall}, 32'd0);

        // Core store then load.
        step(1'b1, 1'b1, 32'h8, 32'h5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("cst_we", {31'd0, mem_we}, 32'd1);
        step(1'b1, 1'b0, 32'h8, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("cld_rdata", core_rdata, 32'h5);

        // Halt for 10 cycles while loading 4 words.
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0, 32'h0, 32'd0, (c >= 1 && c <= 4), 1'b1, 32'h40 + 32'(4 * c),
                 32'h1000 + 32'(c), 1'b1);
            if (dbg_rvalid) pulses++;
        end
        check("halt_pulses", 32'(pulses), 32'd4);
        check("halt_halted", {31'd0, halted}, 32'd1);
        step(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'h44, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_rdata", core_rdata, 32'h1001);

        // Reset right after a debug read acceptance.
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h44, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        dbg_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        check("rst_rdata", dbg_rdata, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();

        // Halt request coinciding with a forced grant.
        for (int c = 1; c <= int'(LIMIT) + 1; c++)
            step(1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 1'b0, 32'h2C, 32'd0, (c == int'(LIMIT) + 1));
        step(1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        check("hf_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("hf_halted", {31'd0, halted}, 32'd1);
        check("hf_rdata", dbg_rdata, 32'hA500_000B);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), {24'd0, 6'($urandom), 2'b00},
                 $urandom, $urandom_range(0, 1) == 1, 1'($urandom),
                 {24'd0, 6'($urandom), 2'b00}, $urandom, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
